// File: rtl/prbs16_checker.sv
// Serial PRBS-16 checker: self-synchronises to b[n]=b[n-16]^b[n-15]^b[n-13]^b[n-4],
// reports lock and counts bit errors. Define PRBS_CHK_SATURATE_EN to make err_count saturate.
module prbs16_checker #(
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WE_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
    localparam logic [WE_W-1:0] ERR_LAST = WE_W'(LOSS_THRESH - 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic prbs_predict(input logic [15:0] sr);
        return sr[15] ^ sr[14] ^ sr[12] ^ sr[3];
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [15:0]            sr_r, sr_nxt_s;
    logic [3:0]             fill_r, fill_nxt_s;
    logic [WC_W-1:0]        win_cnt_r, win_cnt_nxt_s;
    logic [WE_W-1:0]        win_err_r, win_err_nxt_s;
    logic [ERR_CNT_W-1:0]   err_count_r, err_count_nxt_s;
    logic                   err_pulse_r, err_pulse_nxt_s;
    logic                   locked_r;
    logic                   valid_s;
    logic                   pred_s;
    logic                   mismatch_s;

    assign valid_s    = en & din_valid;
    assign pred_s     = prbs_predict(sr_r);
    assign mismatch_s = din ^ pred_s;

    // Next-state, shift register, window counters and error accounting.
    always_comb begin
        state_nxt_s     = state_r;
        sr_nxt_s        = sr_r;
        fill_nxt_s      = fill_r;
        win_cnt_nxt_s   = win_cnt_r;
        win_err_nxt_s   = win_err_r;
        err_count_nxt_s = err_count_r;
        err_pulse_nxt_s = 1'b0;
        if (valid_s) begin
            case (state_r)
                HUNT: begin
                    sr_nxt_s = {sr_r[14:0], din};
                    if (fill_r == 4'd15) begin
                        fill_nxt_s    = 4'd0;
                        win_cnt_nxt_s = '0;
                        win_err_nxt_s = '0;
                        if (sr_nxt_s != 16'h0000) begin
                            state_nxt_s = LOCKED;
                        end else begin
                            state_nxt_s = HUNT;
                        end
                    end else begin
                        fill_nxt_s = fill_r + 4'd1;
                    end
                end
                LOCKED: begin
                    // The reference free-runs on its own prediction, not on din.
                    sr_nxt_s = {sr_r[14:0], pred_s};
                    if (mismatch_s) begin
                        err_pulse_nxt_s = 1'b1;
`ifdef PRBS_CHK_SATURATE_EN
                        if (err_count_r != {ERR_CNT_W{1'b1}}) begin
                            err_count_nxt_s = err_count_r + ERR_CNT_W'(1);
                        end else begin
                            err_count_nxt_s = err_count_r;
                        end
`else
                        err_count_nxt_s = err_count_r + ERR_CNT_W'(1);
`endif
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                    if (mismatch_s && (win_err_r == ERR_LAST)) begin
                        state_nxt_s   = HUNT;
                        fill_nxt_s    = 4'd0;
                        win_cnt_nxt_s = '0;
                        win_err_nxt_s = '0;
                    end else if (win_cnt_r == WIN_LAST) begin
                        win_cnt_nxt_s = '0;
                        win_err_nxt_s = '0;
                    end else begin
                        win_cnt_nxt_s = win_cnt_r + WC_W'(1);
                        win_err_nxt_s = win_err_r + WE_W'(mismatch_s);
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    fill_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        // Clear wins over a coincident increment; the pulse still fires.
        if (en && clr_cnt) begin
            err_count_nxt_s = '0;
        end else begin
            err_count_nxt_s = err_count_nxt_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            sr_r        <= 16'h0000;
            fill_r      <= 4'd0;
            win_cnt_r   <= '0;
            win_err_r   <= '0;
            err_count_r <= '0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sr_r        <= sr_nxt_s;
            fill_r      <= fill_nxt_s;
            win_cnt_r   <= win_cnt_nxt_s;
            win_err_r   <= win_err_nxt_s;
            err_count_r <= err_count_nxt_s;
            err_pulse_r <= err_pulse_nxt_s;
            locked_r    <= (state_nxt_s == LOCKED);
        end
    end

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;

endmodule
